// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared state encoding, default sizes and halt-word fill for the instruction memory.
package inst_mem_pkg;
    localparam int IW_DEF    = 8;
    localparam int AW_DEF    = 8;
    localparam int DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_t;

    function automatic logic [63:0] halt_fill(input int w);
        return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    endfunction
endpackage

// File: rtl/inst_mem_array.sv
// inst_mem_array: word storage with per-word valid flags and a registered read port; INST_MEM_PARITY_EN adds parity bits.
module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [IW-1:0] wr_data_i,
`ifdef INST_MEM_PARITY_EN
    input  logic          wr_par_inv_i,
`endif
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [IW-1:0] rd_data_o,
    output logic          rd_valid_o,
    output logic          rd_perr_o
);
    localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] HALT = IW'(halt_fill(IW));

    logic [IW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [IW-1:0]    r_rd_data;
    logic             r_rd_valid;
    logic [DW-1:0]    w_wr_idx;
    logic [DW-1:0]    w_rd_idx;
    logic             w_wr_hit;
    logic             w_rd_ok;

    assign w_wr_idx   = wr_addr_i[DW-1:0];
    assign w_rd_idx   = rd_addr_i[DW-1:0];
    assign w_wr_hit   = wr_en_i && (int'(wr_addr_i) < DEPTH);
    assign w_rd_ok    = (int'(rd_addr_i) < DEPTH) && r_valid[w_rd_idx];
    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;

    always_ff @(posedge clk_i) begin
        if (w_wr_hit) r_mem[w_wr_idx] <= wr_data_i;
    end

    // a clear and a write in the same cycle leave only the new word valid
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= '0;
        end else begin
            if (clr_i) r_valid <= '0;
            if (w_wr_hit) r_valid[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_data  <= HALT;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en_i;
            if (rd_en_i) r_rd_data <= w_rd_ok ? r_mem[w_rd_idx] : HALT;
        end
    end

`ifdef INST_MEM_PARITY_EN
    logic [DEPTH-1:0] r_par;
    logic             r_rd_perr;

    always_ff @(posedge clk_i) begin
        if (w_wr_hit) r_par[w_wr_idx] <= (^wr_data_i) ^ wr_par_inv_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_rd_perr <= 1'b0;
        else r_rd_perr <= rd_en_i && w_rd_ok && ((^r_mem[w_rd_idx]) != r_par[w_rd_idx]);
    end

    assign rd_perr_o = r_rd_perr;
`else
    assign rd_perr_o = 1'b0;
`endif
endmodule

// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: program loader handshake and fetch control over inst_mem_array.
// Define INST_MEM_PARITY_EN to add per-word parity and the parity_inject_i port.
module inst_mem_ctrl
    import inst_mem_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          fetch_en_i,
    input  logic [AW-1:0] address_i,
    output logic [IW-1:0] data_o,
    output logic          data_valid_o,
    input  logic          load_valid_i,
    output logic          load_ready_o,
    input  logic [AW-1:0] load_addr_i,
    input  logic [IW-1:0] load_data_i,
`ifdef INST_MEM_PARITY_EN
    input  logic          parity_inject_i,
`endif
    input  logic          load_last_i,
    output logic          ready_o,
    output logic          parity_err_o
);
    state_t r_state;
    logic   w_xfer;
    logic   w_fetch;
    logic   w_clr;

    assign load_ready_o = 1'b1;
    assign w_xfer       = load_valid_i && load_ready_o;
    assign w_fetch      = (r_state == READY) && fetch_en_i && !w_xfer;
    assign w_clr        = w_xfer && (r_state != LOADING);
    assign ready_o      = (r_state == READY);

    // every state accepts loads; the last flag decides whether the program is complete
    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= EMPTY;
        else if (w_xfer) r_state <= load_last_i ? READY : LOADING;
    end

    inst_mem_array #(
        .IW   (IW),
        .AW   (AW),
        .DEPTH(DEPTH)
    ) u_array (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clr_i       (w_clr),
        .wr_en_i     (w_xfer),
        .wr_addr_i   (load_addr_i),
        .wr_data_i   (load_data_i),
`ifdef INST_MEM_PARITY_EN
        .wr_par_inv_i(parity_inject_i),
`endif
        .rd_en_i     (w_fetch),
        .rd_addr_i   (address_i),
        .rd_data_o   (data_o),
        .rd_valid_o  (data_valid_o),
        .rd_perr_o   (parity_err_o)
    );
endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb_inst_mem_ctrl: table-driven bench with a fetch-result scoreboard for inst_mem_ctrl (DEPTH=128).
module tb_inst_mem_ctrl;
    typedef struct {
        logic       fe;
        logic [7:0] fa;
        logic       lv;
        logic [7:0] la;
        logic [7:0] ld;
        logic       ll;
        logic       ef;
        logic [7:0] ed;
        logic       ep;
        logic       er;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       fetch_en_i = 1'b0;
    logic [7:0] address_i = '0;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       load_valid_i = 1'b0;
    logic       load_ready_o;
    logic [7:0] load_addr_i = '0;
    logic [7:0] load_data_i = '0;
    logic       load_last_i = 1'b0;
    logic       ready_o;
    logic       parity_err_o;
    logic       inj = 1'b0;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] q[$];
    logic [7:0] last_data = 8'hFF;
    vec_t       tbl[$];

    always #5 clk_i = ~clk_i;

    inst_mem_ctrl #(.IW(8), .AW(8), .DEPTH(128)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .fetch_en_i     (fetch_en_i),
        .address_i      (address_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .load_valid_i   (load_valid_i),
        .load_ready_o   (load_ready_o),
        .load_addr_i    (load_addr_i),
        .load_data_i    (load_data_i),
`ifdef INST_MEM_PARITY_EN
        .parity_inject_i(inj),
`endif
        .load_last_i    (load_last_i),
        .ready_o        (ready_o),
        .parity_err_o   (parity_err_o)
    );

    function automatic vec_t mk(input logic fe, input logic [7:0] fa, input logic lv, input logic [7:0] la,
                                input logic [7:0] ld, input logic ll, input logic ef, input logic [7:0] ed,
                                input logic ep, input logic er);
        vec_t v;
        v.fe = fe; v.fa = fa; v.lv = lv; v.la = la; v.ld = ld; v.ll = ll;
        v.ef = ef; v.ed = ed; v.ep = ep; v.er = er;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [8:0] e;
        fetch_en_i   = v.fe;
        address_i    = v.fa;
        load_valid_i = v.lv;
        load_addr_i  = v.la;
        load_data_i  = v.ld;
        load_last_i  = v.ll;
        if (v.ef) q.push_back({v.ep, v.ed});
        @(posedge clk_i);
        #1;
        fetch_en_i   = 1'b0;
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
        chk("data_valid", 32'(data_valid_o), 32'(v.ef));
        chk("ready", 32'(ready_o), 32'(v.er));
        chk("load_ready", 32'(load_ready_o), 32'd1);
        if (data_valid_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got data %0h expected no result", data_o);
            end else begin
                e = q.pop_front();
                chk("data", 32'(data_o), 32'(e[7:0]));
                chk("parity_err", 32'(parity_err_o), 32'(e[8]));
                last_data = e[7:0];
            end
        end else begin
            chk("data_hold", 32'(data_o), 32'(last_data));
            chk("parity_idle", 32'(parity_err_o), 32'd0);
        end
    endtask

    task automatic rst_cyc(input logic fe, input logic lv);
        reset_i      = 1'b1;
        fetch_en_i   = fe;
        address_i    = 8'd0;
        load_valid_i = lv;
        load_addr_i  = 8'd13;
        load_data_i  = 8'hD3;
        @(posedge clk_i);
        #1;
        reset_i      = 1'b0;
        fetch_en_i   = 1'b0;
        load_valid_i = 1'b0;
        chk("rst_valid", 32'(data_valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'hFF);
        chk("rst_perr", 32'(parity_err_o), 32'd0);
        last_data = 8'hFF;
        q.delete();
    endtask

    initial begin
        tbl.push_back(mk(1, 0,   0, 0,   0,     0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0,   1, 0,   8'hC1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0,   1, 1,   8'h90, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0,   1, 2,   8'h88, 1, 0, 0,     0, 1));
        tbl.push_back(mk(1, 0,   0, 0,   0,     0, 1, 8'hC1, 0, 1));
        tbl.push_back(mk(1, 1,   0, 0,   0,     0, 1, 8'h90, 0, 1));
        tbl.push_back(mk(1, 2,   0, 0,   0,     0, 1, 8'h88, 0, 1));
        tbl.push_back(mk(0, 0,   0, 0,   0,     0, 0, 0,     0, 1));
        tbl.push_back(mk(1, 5,   0, 0,   0,     0, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(1, 200, 0, 0,   0,     0, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(1, 1,   1, 0,   8'h11, 0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 0,   0, 0,   0,     0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0,   1, 2,   8'hAA, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0,   1, 2,   8'hBB, 1, 0, 0,     0, 1));
        tbl.push_back(mk(1, 0,   0, 0,   0,     0, 1, 8'h11, 0, 1));
        tbl.push_back(mk(1, 1,   0, 0,   0,     0, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(1, 2,   0, 0,   0,     0, 1, 8'hBB, 0, 1));
        tbl.push_back(mk(0, 0,   1, 3,   8'h33, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0,   1, 127, 8'h7F, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0,   1, 150, 8'h55, 1, 0, 0,     0, 1));
        tbl.push_back(mk(1, 3,   0, 0,   0,     0, 1, 8'h33, 0, 1));
        tbl.push_back(mk(1, 0,   0, 0,   0,     0, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(1, 150, 0, 0,   0,     0, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(1, 127, 0, 0,   0,     0, 1, 8'h7F, 0, 1));
        tbl.push_back(mk(0, 0,   0, 0,   0,     0, 0, 0,     0, 1));
        tbl.push_back(mk(1, 128, 0, 0,   0,     0, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(1, 22,  0, 0,   0,     0, 1, 8'hFF, 0, 1));

        rst_cyc(1'b0, 1'b0);
        rst_cyc(1'b0, 1'b0);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // reset in the middle of a reload discards the partial program
        apply(mk(0, 0,  1, 10, 8'hA0, 0, 0, 0,     0, 0));
        apply(mk(0, 0,  1, 11, 8'hA1, 0, 0, 0,     0, 0));
        apply(mk(0, 0,  1, 12, 8'hA2, 0, 0, 0,     0, 0));
        rst_cyc(1'b0, 1'b1);
        apply(mk(1, 0,  0, 0,  0,     0, 0, 0,     0, 0));
        apply(mk(0, 0,  1, 0,  8'h5A, 1, 0, 0,     0, 1));
        apply(mk(1, 0,  0, 0,  0,     0, 1, 8'h5A, 0, 1));
        apply(mk(1, 10, 0, 0,  0,     0, 1, 8'hFF, 0, 1));
        apply(mk(1, 13, 0, 0,  0,     0, 1, 8'hFF, 0, 1));

        // reset on the same edge as an accepted fetch drops the result
        rst_cyc(1'b1, 1'b0);
        apply(mk(1, 0,  0, 0,  0,     0, 0, 0,     0, 0));

`ifdef INST_MEM_PARITY_EN
        apply(mk(0, 0,  1, 0,  8'hC1, 0, 0, 0,     0, 0));
        inj = 1'b1;
        apply(mk(0, 0,  1, 4,  8'h3C, 1, 0, 0,     0, 1));
        inj = 1'b0;
        apply(mk(1, 4,  0, 0,  0,     0, 1, 8'h3C, 1, 1));
        apply(mk(1, 0,  0, 0,  0,     0, 1, 8'hC1, 0, 1));
        apply(mk(1, 5,  0, 0,  0,     0, 1, 8'hFF, 0, 1));
        apply(mk(1, 200, 0, 0, 0,     0, 1, 8'hFF, 0, 1));
`endif

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
